// File: rtl/ahb_mtx_in_stg.sv
// Per-master input stage of the single-layer AHB bus matrix: holds a denied address phase until granted.
// Optional macro AHB_MTX_IN_STG_WAIT_CNT_EN adds the pend_cycles wait counter output.
module ahb_mtx_in_stg #(
   parameter int ADDR_WIDTH = 32,
   parameter int PROT_WIDTH = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic [1:0]            HTRANSS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [PROT_WIDTH-1:0] HPROTS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   output logic                  HREADYOUTS,
   output logic [1:0]            HRESPS,
   output logic                  req_port,
   output logic                  HSEL_O,
   output logic [ADDR_WIDTH-1:0] HADDR_O,
   output logic [1:0]            HTRANS_O,
   output logic                  HWRITE_O,
   output logic [2:0]            HSIZE_O,
   output logic [2:0]            HBURST_O,
   output logic [PROT_WIDTH-1:0] HPROT_O,
   output logic                  HMASTLOCK_O,
   input  logic                  addr_grant,
   input  logic                  data_sel,
   input  logic                  HREADYOUTM,
   input  logic [1:0]            HRESPM
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
   ,
   output logic [7:0]            pend_cycles
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [1:0]            trans;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [PROT_WIDTH-1:0] prot;
      logic                  lock;
   } addr_phase_t;

   state_t      state_q, state_d;
   addr_phase_t held_q, held_d;
   addr_phase_t live;
   addr_phase_t fwd;
   logic        trans_req;
   logic        load;
   logic        release_ok;
   logic        pend_valid;
   logic        capture;

   assign live       = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                         burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};
   assign trans_req  = HSELS & HTRANSS[1];
   assign load       = trans_req & HREADYS;
   assign release_ok = addr_grant & HREADYOUTM;
   assign pend_valid = (state_q == ST_HOLD);

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load && !release_ok) begin
               capture = 1'b1;
               held_d  = live;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (release_ok) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   // A held transfer is always a real request, so the select is forced high while holding.
   assign fwd         = pend_valid ? held_q : live;
   assign HSEL_O      = pend_valid | HSELS;
   assign HADDR_O     = fwd.addr;
   assign HTRANS_O    = fwd.trans;
   assign HWRITE_O    = fwd.write;
   assign HSIZE_O     = fwd.size;
   assign HBURST_O    = fwd.burst;
   assign HPROT_O     = fwd.prot;
   assign HMASTLOCK_O = fwd.lock;

   assign req_port = pend_valid | trans_req;

   // Data-phase ownership takes priority; stalling for a held address only applies otherwise.
   assign HREADYOUTS = data_sel ? HREADYOUTM : !pend_valid;
   assign HRESPS     = data_sel ? HRESPM : 2'b00;

`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pend_valid) begin
         if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (capture) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pend_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Self-checking bench for ahb_mtx_in_stg: directed scenarios plus randomized traffic against a queue model.
// Honours AHB_MTX_IN_STG_WAIT_CNT_EN to also check pend_cycles.
module tb_ahb_mtx_in_stg;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        lock;
   } xfer_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        HREADYOUTS;
   logic [1:0]  HRESPS;
   logic        req_port;
   logic        HSEL_O;
   logic [31:0] HADDR_O;
   logic [1:0]  HTRANS_O;
   logic        HWRITE_O;
   logic [2:0]  HSIZE_O;
   logic [2:0]  HBURST_O;
   logic [3:0]  HPROT_O;
   logic        HMASTLOCK_O;
   logic        addr_grant;
   logic        data_sel;
   logic        HREADYOUTM;
   logic [1:0]  HRESPM;
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
   logic [7:0]  pend_cycles;
`endif

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: at most one pending transfer waiting for the arbiter, plus its wait count.
   xfer_t pend_q[$];
   int    pend_cnt = 0;

   always #5 HCLK = ~HCLK;

   ahb_mtx_in_stg #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
      .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
      .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .req_port(req_port),
      .HSEL_O(HSEL_O), .HADDR_O(HADDR_O), .HTRANS_O(HTRANS_O), .HWRITE_O(HWRITE_O),
      .HSIZE_O(HSIZE_O), .HBURST_O(HBURST_O), .HPROT_O(HPROT_O), .HMASTLOCK_O(HMASTLOCK_O),
      .addr_grant(addr_grant), .data_sel(data_sel), .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM)
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
      , .pend_cycles(pend_cycles)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic xfer_t live_xfer();
      return '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
               burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};
   endfunction

   // Compare every DUT output against what the model says it must be this cycle.
   task automatic compare_model();
      logic        held;
      logic [46:0] fwd_exp;
      logic [46:0] fwd_act;
      held    = (pend_q.size() != 0);
      fwd_exp = held ? {1'b1, pend_q[0]} : {HSELS, live_xfer()};
      fwd_act = {HSEL_O, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HMASTLOCK_O};
      check("fwd_bundle", 64'(fwd_act), 64'(fwd_exp));
      check("req_port", 64'(req_port), 64'(held || (HSELS && HTRANSS[1])));
      check("hreadyouts", 64'(HREADYOUTS), 64'(data_sel ? HREADYOUTM : !held));
      check("hresps", 64'(HRESPS), 64'(data_sel ? HRESPM : 2'b00));
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
      check("pend_cycles", 64'(pend_cycles), 64'(pend_cnt));
`endif
   endtask

   task automatic model_clock();
      if (!HRESETn) begin
         pend_q.delete();
         pend_cnt = 0;
      end else if (pend_q.size() != 0) begin
         if (pend_cnt < 255) pend_cnt++;
         if (addr_grant && HREADYOUTM) void'(pend_q.pop_front());
      end else if (HSELS && HTRANSS[1] && HREADYS && !(addr_grant && HREADYOUTM)) begin
         pend_q.push_back(live_xfer());
         pend_cnt = 0;
      end
   endtask

   task automatic settle();
      @(negedge HCLK);
      if (!HRESETn) begin
         pend_q.delete();
         pend_cnt = 0;
      end
      compare_model();
   endtask

   task automatic tick();
      @(posedge HCLK);
      model_clock();
      #1;
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic rdy_s, input logic grant, input logic rdy_m);
      HSELS = sel; HTRANSS = trans; HADDRS = addr;
      HREADYS = rdy_s; addr_grant = grant; HREADYOUTM = rdy_m;
   endtask

   initial begin
      HRESETn = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
      HWRITES = 1'b1; HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
      data_sel = 1'b0; HRESPM = 2'b00;
      #1;
      settle();
      check("reset_hreadyouts", 64'(HREADYOUTS), 64'd1);
      check("reset_hresps", 64'(HRESPS), 64'd0);
      tick(); tick();
      HRESETn = 1'b1;
      tick();

      // 1: granted NONSEQ single passes straight through.
      drive(1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1, 1'b1);
      settle();
      check("t1_haddr", 64'(HADDR_O), 64'h2000_0010);
      check("t1_htrans", 64'(HTRANS_O), 64'd2);
      check("t1_req", 64'(req_port), 64'd1);
      check("t1_ready", 64'(HREADYOUTS), 64'd1);
      tick();
      drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
      settle();
      check("t1_no_hold", 64'(HREADYOUTS), 64'd1);
      tick();

      // 2: denied 3 cycles, granted on the 4th.
      drive(1'b1, 2'b10, 32'h3000_0040, 1'b1, 1'b0, 1'b1);
      settle();
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'b00, 32'h5555_0000 + 32'(i), 1'b0, (i == 2), 1'b1);
         settle();
         check("t2_stall", 64'(HREADYOUTS), 64'd0);
         check("t2_held_addr", 64'(HADDR_O), 64'h3000_0040);
         check("t2_hsel", 64'(HSEL_O), 64'd1);
         tick();
      end
      drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
      settle();
      check("t2_released", 64'(HREADYOUTS), 64'd1);
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
      check("t2_pend_cycles", 64'(pend_cycles), 64'd3);
`endif
      tick();

      // 3: IDLE then BUSY while not granted are never captured.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'(i), 32'h6000_0000, 1'b1, 1'b0, 1'b1);
         settle();
         check("t3_req", 64'(req_port), 64'd0);
         check("t3_ready", 64'(HREADYOUTS), 64'd1);
         tick();
      end
      drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
      settle();
      check("t3_no_capture", 64'(HREADYOUTS), 64'd1);
      tick();

      // 4: two-cycle ERROR response.
      data_sel = 1'b1; HRESPM = 2'b01; HREADYOUTM = 1'b0;
      settle();
      check("t4_resp1", 64'(HRESPS), 64'd1);
      check("t4_ready1", 64'(HREADYOUTS), 64'd0);
      tick();
      HREADYOUTM = 1'b1;
      settle();
      check("t4_resp2", 64'(HRESPS), 64'd1);
      check("t4_ready2", 64'(HREADYOUTS), 64'd1);
      tick();
      data_sel = 1'b0; HRESPM = 2'b00;

      // 5: reset in the middle of a hold.
      drive(1'b1, 2'b10, 32'h7000_0000, 1'b1, 1'b0, 1'b1);
      settle();
      tick();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
      settle();
      check("t5_holding", 64'(HREADYOUTS), 64'd0);
      tick(); tick();
      HRESETn = 1'b0;
      settle();
      check("t5_ready", 64'(HREADYOUTS), 64'd1);
      check("t5_resp", 64'(HRESPS), 64'd0);
      check("t5_req", 64'(req_port), 64'd0);
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
      check("t5_pend_cycles", 64'(pend_cycles), 64'd0);
`endif
      tick();
      HRESETn = 1'b1;
      settle();
      tick();

      // 6: INCR4 burst, grant lost after beat 2.
      HBURSTS = 3'b011;
      drive(1'b1, 2'b10, 32'h4000_0100, 1'b1, 1'b1, 1'b1);
      settle();
      check("t6_beat1", 64'(HADDR_O), 64'h4000_0100);
      tick();
      drive(1'b1, 2'b11, 32'h4000_0104, 1'b1, 1'b1, 1'b1);
      settle();
      check("t6_beat2", 64'(HADDR_O), 64'h4000_0104);
      tick();
      drive(1'b1, 2'b11, 32'h4000_0108, 1'b1, 1'b0, 1'b1);
      settle();
      check("t6_beat3_live", 64'(HADDR_O), 64'h4000_0108);
      tick();
      drive(1'b1, 2'b11, 32'hDEAD_0000, 1'b0, 1'b1, 1'b1);
      settle();
      check("t6_beat3_held", 64'(HADDR_O), 64'h4000_0108);
      check("t6_beat3_stall", 64'(HREADYOUTS), 64'd0);
      tick();
      drive(1'b1, 2'b11, 32'h4000_010C, 1'b1, 1'b0, 1'b1);
      settle();
      check("t6_beat4_live", 64'(HADDR_O), 64'h4000_010C);
      tick();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
      settle();
      check("t6_beat4_held", 64'(HADDR_O), 64'h4000_010C);
      check("t6_beat4_trans", 64'(HTRANS_O), 64'd3);
      check("t6_beat4_burst", 64'(HBURST_O), 64'd3);
      tick();
      drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
      settle();
      check("t6_done", 64'(HREADYOUTS), 64'd1);
      tick();

      // Long hold to reach wait-counter saturation.
      drive(1'b1, 2'b10, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
      settle();
      tick();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 260; i++) begin
         settle();
         tick();
      end
`ifdef AHB_MTX_IN_STG_WAIT_CNT_EN
      settle();
      check("sat_pend_cycles", 64'(pend_cycles), 64'd255);
`endif
      addr_grant = 1'b1;
      settle();
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         HRESETn    = ($urandom_range(0, 299) != 0);
         HSELS      = ($urandom_range(0, 3) != 0);
         HTRANSS    = 2'($urandom_range(0, 3));
         HADDRS     = $urandom;
         HWRITES    = 1'($urandom_range(0, 1));
         HSIZES     = 3'($urandom_range(0, 7));
         HBURSTS    = 3'($urandom_range(0, 7));
         HPROTS     = 4'($urandom_range(0, 15));
         HMASTLOCKS = 1'($urandom_range(0, 1));
         HREADYS    = ($urandom_range(0, 4) != 0);
         addr_grant = 1'($urandom_range(0, 1));
         data_sel   = ($urandom_range(0, 2) == 0);
         HREADYOUTM = ($urandom_range(0, 3) != 0);
         HRESPM     = 2'($urandom_range(0, 3));
         settle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_mtx_in_stg.md
Name: ahb_mtx_in_stg

Overview:
- Per-master input stage of the single-layer AHB bus matrix; sits directly upstream of the output-port arbiter and output stage.
- Captures a master's address phase when the output port is not granted to it.
- Holds that address phase until the arbiter selects this port, and drives the request the arbiter consumes.
- Stalls the master via HREADYOUTS and returns the slave's data-phase response when this port owns the data phase.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/HADDR_O
PROT_WIDTH, 4, width of HPROTS/HPROT_O

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  asynchronous active-low reset
HSELS  in  1  master-side slave select
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write
HSIZES  in  3  master transfer size
HBURSTS  in  3  master burst type
HPROTS  in  PROT_WIDTH  master protection
HMASTLOCKS  in  1  master lock
HREADYS  in  1  master-side HREADY (transfer done on master bus)
HREADYOUTS  out  1  ready back to master
HRESPS  out  2  response back to master
req_port  out  1  request to arbiter
HSEL_O  out  1  select toward output stage
HADDR_O  out  ADDR_WIDTH  forwarded address
HTRANS_O  out  2  forwarded transfer type
HWRITE_O  out  1  forwarded write
HSIZE_O  out  3  forwarded size
HBURST_O  out  3  forwarded burst
HPROT_O  out  PROT_WIDTH  forwarded protection
HMASTLOCK_O  out  1  forwarded lock
addr_grant  in  1  arbiter has selected this port (addr_in_port==this & !no_port)
data_sel  in  1  this port owns the current output data phase
HREADYOUTM  in  1  slave-side ready from output port
HRESPM  in  2  slave-side response from output port

Behaviour:
- trans_req = HSELS & HTRANSS[1] (NONSEQ/SEQ). load = trans_req & HREADYS.
- State register pend_valid; reset 0. Holding registers for addr/trans/write/size/burst/prot/lock; reset 0.
- IDLE state (pend_valid=0):
  - outputs are the live master inputs; HSEL_O = HSELS.
  - On load & !(addr_grant & HREADYOUTM): capture all address-phase signals; pend_valid <= 1 (go HOLD).
  - On load & addr_grant & HREADYOUTM: no capture; the transfer passes straight through, 0 wait states.
- HOLD state (pend_valid=1):
  - outputs are the held registers; HSEL_O = 1.
  - Leave HOLD (pend_valid <= 0) when addr_grant & HREADYOUTM.
  - Holding registers do not change while in HOLD.
- req_port = pend_valid | trans_req. It is combinational, so there is a 0-cycle request on a live transfer.
- HREADYOUTS:
  - data_sel: HREADYOUTM.
  - else pend_valid: 0.
  - else: 1.
  - Reset value 1.
- HRESPS = data_sel ? HRESPM : 2'b00 (OKAY). Reset value 2'b00. ERROR/RETRY pass unchanged, including both cycles of a two-cycle response.
- Simultaneous events:
  - Release of HOLD and a new load in the same cycle: the new transfer is live next cycle, with no capture unless not granted.
  - Data-phase completion and HOLD release in the same cycle are independent. Only pend_valid and data_sel decide HREADYOUTS.
- IDLE/BUSY from the master are never captured. They forward live only in IDLE state.
- Locked sequences: HMASTLOCK_O forwards the held or live value. The arbiter owns lock retention.
- Reset mid-HOLD: pend_valid=0, held transfer discarded, HREADYOUTS=1, req_port follows live inputs.
- Latency:
  - Granted live transfer: 0 added cycles.
  - Held transfer: forwarded the cycle after capture; stall equals cycles until addr_grant & HREADYOUTM.

Optional Feature:
- Macro AHB_MTX_IN_STG_WAIT_CNT_EN.
- Defined:
  - Extra output pend_cycles[7:0], reset 0.
  - Cleared on entry to HOLD; increments by 1 each cycle in HOLD; saturates at 8'hFF.
  - Holds its value after leaving HOLD until the next capture, for performance monitoring.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. Granted NONSEQ single: HSELS=1, HTRANSS=2'b10, HADDRS=32'h2000_0010, addr_grant=1, HREADYOUTM=1 -> same-cycle HADDR_O=32'h2000_0010, HTRANS_O=2'b10, req_port=1, pend_valid stays 0, HREADYOUTS=1.
2. Denied transfer: addr_grant=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles; held HADDR_O constant; release on grant cycle; HREADYOUTS=1 next cycle (pend_cycles=3 with macro).
3. Master IDLE/BUSY with addr_grant=0: HTRANSS=2'b00 then 2'b01 -> no capture, req_port=0, HREADYOUTS=1.
4. Two-cycle ERROR: data_sel=1, HRESPM=2'b01, HREADYOUTM=0 then 1 -> HRESPS=2'b01 both cycles, HREADYOUTS=0 then 1.
5. Reset mid-HOLD: assert HRESETn=0 during HOLD -> HREADYOUTS=1, HRESPS=2'b00, req_port=0 with HSELS=0, pend_cycles=0.
6. Back-to-back INCR4 burst, grant lost after beat 2: beats 3-4 held and forwarded in order; HADDR_O increments by 4 per accepted beat.
